// File: rtl/qft3_job_scheduler_pkg.sv
// Shared widths, latencies and types for the QFT3 job scheduler.
// Amplitude width, datapath latency, vector packing and state/track types.
package qft3_job_scheduler_pkg;

    localparam int TOTAL_WIDTH = 16;
    localparam int QFT3_AMPS   = 8;
    localparam int QFT3_LAT    = 61;
    localparam int QFT3_VEC_W  = 2 * QFT3_AMPS * TOTAL_WIDTH;

    typedef enum logic [1:0] {
        ST_WARMUP,
        ST_RUN,
        ST_DRAIN
    } sched_state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } track_t;

endpackage

// File: rtl/qft3_result_fifo.sv
// Result FIFO: DEPTH entries of {id, vector}, simultaneous push/pop.
// Ports: clk, rst_n, push, push_data, pop, head, full, empty.
import qft3_job_scheduler_pkg::*;

module qft3_result_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = QFT3_VEC_W + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot a same-cycle push needs when full.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= inc(wr_ptr);
            if (do_pop)
                rd_ptr <= inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/qft3_job_scheduler.sv
// Credit-based job scheduler in front of the pipelined QFT3 datapath.
// Ports: two valid/ready requesters, datapath in/out, result FIFO, flush.
import qft3_job_scheduler_pkg::*;

module qft3_job_scheduler #(
    parameter int W      = TOTAL_WIDTH,
    parameter int LAT    = QFT3_LAT,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic [2*QFT3_AMPS*W-1:0] req0_vec,
    input  logic [2*QFT3_AMPS*W-1:0] req1_vec,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic [2*QFT3_AMPS*W-1:0] pipe_in_vec,
    output logic                  pipe_in_valid,
    input  logic [2*QFT3_AMPS*W-1:0] pipe_out_vec,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*QFT3_AMPS*W-1:0] res_vec,
    output logic                  res_id,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  busy
);

    localparam int VW  = 2 * QFT3_AMPS * W;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    sched_state_t   state;
    logic [WCW-1:0] wcnt;
    logic [CW-1:0]  credits;
    logic           rr_prio;
    logic           win;
    logic           issue_ok;
    logic           accept;
    logic           pop;
    track_t         trk [LAT];
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic [VW:0]    fifo_head;

    // rr_prio holds the requester that was not granted last;
    // it resets to 0 so req0 leads after reset.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid)
            win = rr_prio;
        else if (req1_valid)
            win = 1'b1;
    end

    // Credits are judged on the pre-edge count, so a
    // same-cycle pop never frees a slot for an accept.
    assign issue_ok = (state == ST_RUN) && !flush
                    && (credits < CW'(DEPTH));
    assign accept   = issue_ok && (req0_valid || req1_valid);

    assign req0_ready    = accept && !win && req0_valid;
    assign req1_ready    = accept &&  win && req1_valid;
    assign pipe_in_valid = accept;
    assign pipe_in_vec   = !accept ? '0
                         : (win ? req1_vec : req0_vec);

    assign pop  = res_valid & res_ready;
    assign busy = (credits != '0) || (state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WARMUP;
            wcnt       <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            unique case (state)
                ST_WARMUP: begin
                    if (wcnt == WCW'(WARMUP - 1)) begin
                        state <= ST_RUN;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                ST_RUN: begin
                    if (flush)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (credits == '0) begin
                        state      <= ST_RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= ST_WARMUP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
            rr_prio <= 1'b0;
        end else begin
            unique case ({accept, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
            if (accept)
                rr_prio <= ~win;
        end
    end

    // Tracks job ids alongside the datapath; the tail
    // lines up with the cycle pipe_out_vec is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++)
                trk[i] <= '0;
        end else begin
            trk[0] <= '{valid: accept, id: win};
            for (int i = 1; i < LAT; i++)
                trk[i] <= trk[i-1];
        end
    end

    assign fifo_push = trk[LAT-1].valid;

    qft3_result_fifo #(
        .DEPTH (DEPTH),
        .DW    (VW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({trk[LAT-1].id, pipe_out_vec}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_valid         = !fifo_empty;
    assign {res_id, res_vec} = fifo_head;

    no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(fifo_full && fifo_push && !pop)
    );

endmodule

// File: tb/tb_qft3_job_scheduler.sv
// Scoreboard bench for qft3_job_scheduler with a datapath stand-in.
// Covers reset, warmup, latency, round-robin, credits, flush, reset.
import qft3_job_scheduler_pkg::*;

module tb_qft3_job_scheduler;

    localparam int W      = TOTAL_WIDTH;
    localparam int VW     = QFT3_VEC_W;
    localparam int LAT    = QFT3_LAT;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 3;

    typedef logic [VW:0] cv_t;
    typedef struct {
        logic          id;
        logic [VW-1:0] vec;
    } sb_ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [VW-1:0] req0_vec, req1_vec;
    logic          req0_ready, req1_ready;
    logic [VW-1:0] pipe_in_vec;
    logic          pipe_in_valid;
    logic [VW-1:0] pipe_out_vec;
    logic          res_valid, res_ready;
    logic [VW-1:0] res_vec;
    logic          res_id;
    logic          flush, flush_done, busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc0 = 0, n_acc1 = 0, n_pop = 0, n_fd = 0;
    int seen0 = 0, seen1 = 0;
    int acc_edge = 0, last_pop_edge = 0;
    bit once0 = 1'b0, once1 = 1'b0;

    sb_ent_t sb[$];
    logic    grant_log[$];
    sb_ent_t e;
    logic    g;
    logic          hold = 1'b0;
    logic [VW-1:0] hold_vec;
    logic          hold_id;

    logic [VW-1:0] dp [LAT];

    qft3_job_scheduler #(
        .W(W), .LAT(LAT), .DEPTH(DEPTH), .WARMUP(WARMUP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_vec      (req0_vec),
        .req1_vec      (req1_vec),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .pipe_in_vec   (pipe_in_vec),
        .pipe_in_valid (pipe_in_valid),
        .pipe_out_vec  (pipe_out_vec),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_vec       (res_vec),
        .res_id        (res_id),
        .flush         (flush),
        .flush_done    (flush_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: every real part gets i000_r/sqrt(8)
    // (362/1024, rounded) added; imaginary parts pass through.
    function automatic logic [VW-1:0] dp_model(input logic [VW-1:0] v);
        logic [VW-1:0]        o;
        logic signed [W-1:0]  r0;
        logic [W-1:0]         s;
        int                   t;
        r0 = v[W-1:0];
        t  = int'(r0) * 362 + 512;
        s  = W'(t >>> 10);
        for (int k = 0; k < QFT3_AMPS; k++) begin
            if (k == 0)
                o[0 +: W] = s;
            else
                o[2*k*W +: W] = s + v[2*k*W +: W];
            o[(2*k+1)*W +: W] = v[(2*k+1)*W +: W];
        end
        return o;
    endfunction

    always @(posedge clk) begin
        dp[0] <= dp_model(pipe_in_vec);
        for (int i = 1; i < LAT; i++)
            dp[i] <= dp[i-1];
    end
    assign pipe_out_vec = dp[LAT-1];

    task automatic chk(input string tag, input cv_t got, input cv_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < 2 * QFT3_AMPS; i++)
            v[i*W +: W] = W'($urandom_range(0, 255));
        return v;
    endfunction

    // Monitor: scoreboard push on accept, pop/compare on result.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pin_valid", cv_t'(pipe_in_valid),
                cv_t'(req0_ready | req1_ready));
            if (req0_ready || req1_ready) begin
                g = req1_ready;
                chk("one_grant", cv_t'(req0_ready & req1_ready), cv_t'(0));
                chk("rdy_has_valid", cv_t'(g ? req1_valid : req0_valid),
                    cv_t'(1));
                chk("pin_vec", cv_t'(pipe_in_vec),
                    cv_t'(g ? req1_vec : req0_vec));
                sb.push_back('{g, dp_model(g ? req1_vec : req0_vec)});
                grant_log.push_back(g);
                acc_edge = cyc + 1;
                if (g) n_acc1++;
                else   n_acc0++;
            end else begin
                chk("pin_zero", cv_t'(pipe_in_vec), cv_t'(0));
            end
            if (hold) begin
                chk("hold_vec", cv_t'(res_vec), cv_t'(hold_vec));
                chk("hold_id", cv_t'(res_id), cv_t'(hold_id));
            end
            if (res_valid && res_ready) begin
                chk("sb_nonempty", cv_t'(sb.size() != 0), cv_t'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("res_id", cv_t'(res_id), cv_t'(e.id));
                    chk("res_vec", cv_t'(res_vec), cv_t'(e.vec));
                end
                n_pop++;
                last_pop_edge = cyc + 1;
            end
            if (flush_done) n_fd++;
            hold     = res_valid && !res_ready;
            hold_vec = res_vec;
            hold_id  = res_id;
        end else begin
            hold = 1'b0;
        end
    end

    // Advance one cycle; requesters load a fresh vector after
    // each accept, and one-shot requesters drop valid.
    task automatic step();
        @(posedge clk);
        #1;
        if (n_acc0 != seen0) begin
            seen0    = n_acc0;
            req0_vec = rand_vec();
            if (once0) req0_valid = 1'b0;
        end
        if (n_acc1 != seen1) begin
            seen1    = n_acc1;
            req1_vec = rand_vec();
            if (once1) req1_valid = 1'b0;
        end
    endtask

    task automatic chk_reset();
        chk("rst_rdy0", cv_t'(req0_ready), cv_t'(0));
        chk("rst_rdy1", cv_t'(req1_ready), cv_t'(0));
        chk("rst_piv", cv_t'(pipe_in_valid), cv_t'(0));
        chk("rst_pin", cv_t'(pipe_in_vec), cv_t'(0));
        chk("rst_rv", cv_t'(res_valid), cv_t'(0));
        chk("rst_rvec", cv_t'(res_vec), cv_t'(0));
        chk("rst_rid", cv_t'(res_id), cv_t'(0));
        chk("rst_fd", cv_t'(flush_done), cv_t'(0));
        chk("rst_busy", cv_t'(busy), cv_t'(1));
    endtask

    task automatic do_reset();
        step();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        sb.delete();
        grant_log.delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (WARMUP) step();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (sb.size() != 0 || res_valid); i++)
            step();
        chk("drain_sb", cv_t'(sb.size()), cv_t'(0));
    endtask

    task automatic wait_acc0(input int b);
        for (int i = 0; i < 20 && n_acc0 == b; i++)
            step();
        chk("acc0_wait", cv_t'(n_acc0 - b), cv_t'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b0, b1, bfd, bpop, rel;
        bit stale;
        logic [VW-1:0] imp;

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_vec   = rand_vec();
        req1_vec   = rand_vec();
        res_ready  = 1'b1;
        flush      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();

        // Single job: warmup gating, latency and scaled output.
        step();
        imp        = '0;
        imp[W-1:0] = W'(16);
        req1_valid = 1'b0;
        req0_vec   = imp;
        once0      = 1'b1;
        rst_n      = 1'b1;
        rel        = cyc;
        step();
        chk("warm_busy", cv_t'(busy), cv_t'(1));
        for (int i = 0; i < 20 && n_acc0 == 0; i++)
            step();
        chk("warm_acc", cv_t'(n_acc0), cv_t'(1));
        chk("warm_edge", cv_t'(acc_edge - rel), cv_t'(WARMUP + 1));
        for (int i = 0; i < LAT + 20 && !res_valid; i++)
            step();
        chk("lat", cv_t'(cyc - acc_edge), cv_t'(LAT));
        chk("id0", cv_t'(res_id), cv_t'(0));
        for (int k = 0; k < QFT3_AMPS; k++)
            chk("f_r", cv_t'(res_vec[2*k*W +: W]), cv_t'(6));
        step();
        chk("idle_busy", cv_t'(busy), cv_t'(0));

        // Contention: alternating grants from reset.
        do_reset();
        once0      = 1'b0;
        once1      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 400 && grant_log.size() < 8; i++)
            step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_count", cv_t'(grant_log.size()), cv_t'(8));
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("rr_order", cv_t'(grant_log[i]), cv_t'(i % 2));
        wait_drain();

        // Backpressure: credits cap accepts at DEPTH.
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        b0         = n_acc0;
        repeat (LAT + 20) step();
        chk("bp_accepts", cv_t'(n_acc0 - b0), cv_t'(DEPTH));
        chk("bp_ready", cv_t'(req0_ready), cv_t'(0));
        chk("bp_rvalid", cv_t'(res_valid), cv_t'(1));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        repeat (10) step();
        chk("bp_one_more", cv_t'(n_acc0 - b0), cv_t'(DEPTH + 1));

        // Full boundary: pop with count at DEPTH grants nothing.
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        once1      = 1'b1;
        b1         = n_acc1;
        res_ready  = 1'b1;
        step();
        res_ready = 1'b0;
        chk("full_none", cv_t'(n_acc1 - b1), cv_t'(0));
        step();
        chk("full_next", cv_t'(n_acc1 - b1), cv_t'(1));
        res_ready = 1'b1;
        wait_drain();

        // Flush: three jobs, then drain with req1 waiting.
        once0 = 1'b1;
        bpop  = n_pop;
        for (int j = 0; j < 3; j++) begin
            b0         = n_acc0;
            req0_valid = 1'b1;
            wait_acc0(b0);
        end
        once1      = 1'b0;
        req1_valid = 1'b1;
        flush      = 1'b1;
        b1         = n_acc1;
        bfd        = n_fd;
        step();
        flush = 1'b0;
        for (int i = 0; i < LAT + 40 && !flush_done; i++)
            step();
        chk("fd_seen", cv_t'(flush_done), cv_t'(1));
        chk("fd_pops", cv_t'(n_pop - bpop), cv_t'(3));
        chk("fd_edge", cv_t'(cyc - last_pop_edge), cv_t'(1));
        chk("fd_noacc", cv_t'(n_acc1 - b1), cv_t'(0));
        step();
        step();
        chk("fd_once", cv_t'(n_fd - bfd), cv_t'(1));
        chk("run_resume", cv_t'((n_acc1 - b1) > 0), cv_t'(1));
        req1_valid = 1'b0;
        wait_drain();

        // Reset mid-run with jobs in flight and in the FIFO.
        once0      = 1'b0;
        req0_valid = 1'b1;
        res_ready  = 1'b0;
        repeat (LAT + 8) step();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_reset();
        step();
        step();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        flush     = 1'b1;
        bfd       = n_fd;
        step();
        flush = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            step();
            stale = stale | res_valid;
        end
        chk("no_stale", cv_t'(stale), cv_t'(0));
        chk("wu_flush_ign", cv_t'(n_fd - bfd), cv_t'(0));
        chk("post_rst_busy", cv_t'(busy), cv_t'(0));
        once0      = 1'b1;
        b0         = n_acc0;
        req0_valid = 1'b1;
        wait_acc0(b0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
